// File: rtl/sao_apply_n_pix_if.sv
// Stream and parameter bus of sao_apply_n_pix: CTB config in, neighbour-aligned
// pixel beats in, filtered beats out. The master drives config/pixels, the slave is the filter.
interface sao_apply_n_pix_if #(
  parameter int unsigned bit_depth  = 8,
  parameter int unsigned n_pix      = 4,
  parameter int unsigned offset_bit = 4
);
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [1:0]                    cfg_sao_type;
  logic [4*offset_bit-1:0]       cfg_offset;
  logic [4:0]                    cfg_band_pos;
  logic                          in_valid;
  logic                          in_ready;
  logic [n_pix*bit_depth-1:0]    in_rec_m;
  logic [n_pix*bit_depth-1:0]    in_rec_l;
  logic [n_pix*bit_depth-1:0]    in_rec_r;
  logic                          out_valid;
  logic                          out_ready;
  logic [n_pix*bit_depth-1:0]    out_pix;
  logic                          ctb_done;

  modport master (
    output cfg_valid, cfg_sao_type, cfg_offset, cfg_band_pos,
    output in_valid, in_rec_m, in_rec_l, in_rec_r, out_ready,
    input  cfg_ready, in_ready, out_valid, out_pix, ctb_done
  );

  modport slave (
    input  cfg_valid, cfg_sao_type, cfg_offset, cfg_band_pos,
    input  in_valid, in_rec_m, in_rec_l, in_rec_r, out_ready,
    output cfg_ready, in_ready, out_valid, out_pix, ctb_done
  );
endinterface

// File: rtl/sao_apply_n_pix.sv
// SAO edge-offset filter, n_pix pixels per beat, 2-stage pipeline with per-CTB FSM.
// Define SAO_BAND_EN to enable band offset for sao_type 1 (otherwise pass-through).
module sao_apply_n_pix #(
  parameter int unsigned bit_depth  = 8,
  parameter int unsigned n_pix      = 4,
  parameter int unsigned offset_bit = 4,
  parameter int unsigned ctb_beats  = 1024
) (
  input logic              clk,
  input logic              rst,
  sao_apply_n_pix_if.slave io
);
  localparam int unsigned CW = (ctb_beats > 1) ? $clog2(ctb_beats) : 1;
  localparam int unsigned SW = bit_depth + 2;
  localparam int unsigned PW = n_pix * bit_depth;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              type_q;
  logic [4*offset_bit-1:0] offs_q;
`ifdef SAO_BAND_EN
  logic [4:0]              bpos_q;
`endif
  logic                    s1_vld_q, s1_last_q;
  logic [PW-1:0]           s1_m_q;
  logic [2*n_pix-1:0]      s1_sl_q, s1_sr_q, sl_d, sr_d;
  logic                    s2_vld_q, s2_last_q;
  logic [PW-1:0]           s2_pix_q, s2_pix_d;
  logic                    s2_adv, s1_load, in_hs, out_hs, last_beat;

  function automatic logic signed [SW-1:0] slot_ext(input logic [4*offset_bit-1:0] o,
                                                    input logic [1:0] k);
    logic [offset_bit-1:0] v;
    v = o[k*offset_bit +: offset_bit];
    return {{(SW-offset_bit){v[offset_bit-1]}}, v};
  endfunction

  assign s2_adv       = !s2_vld_q || io.out_ready;
  assign s1_load      = !s1_vld_q || s2_adv;
  assign in_hs        = io.in_valid && io.in_ready;
  assign out_hs       = s2_vld_q && io.out_ready;
  assign last_beat    = (cnt_q == CW'(ctb_beats - 1));
  assign io.in_ready  = (state_q == RUN) && s1_load;
  assign io.cfg_ready = (state_q == IDLE);
  assign io.out_valid = s2_vld_q;
  assign io.out_pix   = s2_pix_q;
  assign io.ctb_done  = out_hs && s2_last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (io.cfg_valid) state_d = RUN;
      RUN: begin
        if (in_hs) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: if (io.ctb_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: sign(m-l), sign(m-r) as 2-bit two's complement {-1,0,+1}
  always_comb begin
    logic [bit_depth-1:0] m, l, r;
    sl_d = '0;
    sr_d = '0;
    for (int unsigned i = 0; i < n_pix; i++) begin
      m = io.in_rec_m[i*bit_depth +: bit_depth];
      l = io.in_rec_l[i*bit_depth +: bit_depth];
      r = io.in_rec_r[i*bit_depth +: bit_depth];
      sl_d[2*i +: 2] = (m > l) ? 2'b01 : ((m < l) ? 2'b11 : 2'b00);
      sr_d[2*i +: 2] = (m > r) ? 2'b01 : ((m < r) ? 2'b11 : 2'b00);
    end
  end

  // Stage 2: offset select, add, clip
  always_comb begin
    logic [bit_depth-1:0]  m;
    logic [2:0]            idx;
    logic signed [SW-1:0]  add, sum;
`ifdef SAO_BAND_EN
    logic [4:0]            rel;
`endif
    s2_pix_d = '0;
    for (int unsigned i = 0; i < n_pix; i++) begin
      m   = s1_m_q[i*bit_depth +: bit_depth];
      idx = 3'd2 + {s1_sl_q[2*i+1], s1_sl_q[2*i +: 2]} + {s1_sr_q[2*i+1], s1_sr_q[2*i +: 2]};
      add = '0;
      if (type_q == 2'd2) begin
        case (idx)
          3'd0:    add = slot_ext(offs_q, 2'd0);
          3'd1:    add = slot_ext(offs_q, 2'd1);
          3'd3:    add = slot_ext(offs_q, 2'd2);
          3'd4:    add = slot_ext(offs_q, 2'd3);
          default: add = '0;
        endcase
      end
`ifdef SAO_BAND_EN
      rel = m[bit_depth-1 -: 5] - bpos_q;
      if (type_q == 2'd1 && rel < 5'd4) add = slot_ext(offs_q, rel[1:0]);
`endif
      sum = $signed({2'b00, m}) + add;
      if (sum[SW-1])           s2_pix_d[i*bit_depth +: bit_depth] = '0;
      else if (sum[bit_depth]) s2_pix_d[i*bit_depth +: bit_depth] = '1;
      else                     s2_pix_d[i*bit_depth +: bit_depth] = sum[bit_depth-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      type_q    <= '0;
      offs_q    <= '0;
`ifdef SAO_BAND_EN
      bpos_q    <= '0;
`endif
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_m_q    <= '0;
      s1_sl_q   <= '0;
      s1_sr_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_pix_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && io.cfg_valid) begin
        type_q <= io.cfg_sao_type;
        offs_q <= io.cfg_offset;
`ifdef SAO_BAND_EN
        bpos_q <= io.cfg_band_pos;
`endif
      end
      if (s1_load) begin
        s1_vld_q  <= in_hs;
        s1_last_q <= last_beat;
        s1_m_q    <= io.in_rec_m;
        s1_sl_q   <= sl_d;
        s1_sr_q   <= sr_d;
      end
      if (s2_adv) begin
        s2_vld_q  <= s1_vld_q;
        s2_last_q <= s1_last_q;
        if (s1_vld_q) s2_pix_q <= s2_pix_d;
      end
    end
  end
endmodule
